yuv_to_rgb_csc: RTL and testbench
=================================

YUV_TO_RGB_CSC -- requirements
Module: yuv_to_rgb_csc

Interface
REQ-001 CLOCK_50_I  input  1  sole clock; all logic rising-edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_valid  input  1  pixel-pair operands valid.
REQ-004 in_ready  output  1  block can accept a pixel pair.
REQ-005 Y_data  input  16  Y pair: even pixel [15:8], odd pixel [7:0], unsigned.
REQ-006 even_U, even_V  input  8 each  co-sited chroma for the even pixel, unsigned.
REQ-007 odd_U, odd_V  input  32 each  interpolated chroma for the odd pixel from the upsampling FIR, two's complement.
REQ-008 out_valid  output  1  RGB_data holds a valid packed word.
REQ-009 out_ready  input  1  consumer accepts the word.
REQ-010 RGB_data  output  16  packed RGB word for SRAM write.
REQ-011 word_sel  output  2  index (0..2) of the word on RGB_data.
REQ-012 clip_count  output  16  count of saturated colour components (see Configuration).

Function
REQ-013 FSM states: IDLE, M0, M1, M2, M3, M4, OUT0, OUT1, OUT2.
REQ-014 in_ready = 1 only in IDLE.
REQ-015 Accept = in_valid && in_ready at an edge; all inputs are registered at that edge; IDLE -> M0.
REQ-016 At capture, odd_U/odd_V clip to [0,255]: negative -> 0, >255 -> 255; the low 8 bits are then used.
REQ-017 Offsets: Y' = Y-16, U' = U-128, V' = V-128, all signed.
REQ-018 Products: R = 76284*Y' + 104595*V'; G = 76284*Y' - 25624*U' - 53281*V'; B = 76284*Y' + 132251*U'; signed 32-bit accumulation.
REQ-019 At most two multipliers. M0: both Y products; M1: even U products; M2: even V products; M3: odd U products; M4: odd V products. Each M state lasts one cycle; M0..M3 advance unconditionally and M4 -> OUT0.
REQ-020 Each component = accumulated sum arithmetically shifted right by 16, then clipped: <0 -> 0, >255 -> 255.
REQ-021 out_valid = 1 exactly in OUT0..OUT2; first word appears in the 6th cycle after the accept edge.
REQ-022 Output words: OUT0 {R0,G0}, OUT1 {B0,R1}, OUT2 {G1,B1}, with the first component in [15:8]. word_sel = 0/1/2 respectively.
REQ-023 OUTn advances only on out_valid && out_ready; while out_ready = 0, RGB_data and word_sel hold stable.
REQ-024 OUT2 handshake -> IDLE; minimum 9 cycles per pixel pair.
REQ-025 Inputs change outside the accept edge with no effect on an in-flight pair.

Reset
REQ-026 reset = 1 at an edge: state IDLE, out_valid 0, RGB_data 0, word_sel 0, clip_count 0, accumulators 0; in_ready = 1 in the following cycle.
REQ-027 Reset mid-operation (any M or OUT state) discards the pair; no further words are emitted for it.
REQ-028 reset takes priority over accept and output handshakes in the same cycle.

Configuration
REQ-029 Macro CSC_CLIP_COUNT_EN defined: clip_count increments by the number of components (0..6) saturated per pair, updated on the M4 -> OUT0 edge, and saturates at 16'hFFFF.
REQ-030 Macro CSC_CLIP_COUNT_EN absent: clip_count is tied to 0, no counter logic is built, and all other behaviour is identical.

Verification
REQ-031 Y_data=16'h1010, even_U=even_V=128, odd_U=odd_V=128 -> words 16'h0000, 16'h0000, 16'h0000; word_sel 0,1,2.
REQ-032 Y_data=16'hEBFF, all chroma 128 -> R0=G0=B0=254 (0xFE), odd pixel saturates to 255 -> words 16'hFEFE, 16'hFEFF, 16'hFFFF; with CSC_CLIP_COUNT_EN, clip_count=3.
REQ-033 Y_data=16'h5151, even_U=128, even_V=240, odd_U=128, odd_V=240 -> R=254, G=0, B=75 -> words 16'hFE00, 16'h4BFE, 16'h004B.
REQ-034 odd_U=32'hFFFFFFF0, odd_V=32'h00000190 -> clipped to 0 and 255 before use; odd-pixel results match a reference model fed U=0, V=255.
REQ-035 Hold out_ready=0 for 5 cycles in OUT1 -> RGB_data and word_sel stay stable and in_ready stays 0; OUT2 follows the cycle after out_ready=1.
REQ-036 Assert reset in M2, then issue a new pair -> no stale words appear; the new pair's first word appears 6 cycles after its accept edge.

Source files
------------

// File: rtl/yuv_to_rgb_csc.sv
// YUV 4:2:2 pixel-pair to packed RGB converter using two shared multipliers.
// Optional saturation counter enabled by defining CSC_CLIP_COUNT_EN.
module yuv_to_rgb_csc (
  input  logic        CLOCK_50_I,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] Y_data,
  input  logic [7:0]  even_U,
  input  logic [7:0]  even_V,
  input  logic [31:0] odd_U,
  input  logic [31:0] odd_V,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] RGB_data,
  output logic [1:0]  word_sel,
  output logic [15:0] clip_count
);

  // state | meaning
  // IDLE  | waiting for a pixel pair
  // M0    | Y products for both pixels
  // M1    | even-pixel U products
  // M2    | even-pixel V products
  // M3    | odd-pixel U products
  // M4    | odd-pixel V products, first word loaded
  // OUT0  | word {R0,G0} presented
  // OUT1  | word {B0,R1} presented
  // OUT2  | word {G1,B1} presented
  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, OUT0, OUT1, OUT2} state_t;

  localparam logic signed [31:0] K_Y  = 32'sd76284;
  localparam logic signed [31:0] K_RV = 32'sd104595;
  localparam logic signed [31:0] K_GU = -32'sd25624;
  localparam logic signed [31:0] K_GV = -32'sd53281;
  localparam logic signed [31:0] K_BU = 32'sd132251;

  state_t state;
  logic [7:0] y0, y1, u0, v0, u1, v1;
  logic signed [31:0] acc_r0, acc_g0, acc_b0, acc_r1, acc_g1, acc_b1;
  logic signed [31:0] coef_a, coef_b, op_a, op_b, prod_a, prod_b;
  logic signed [31:0] r1_next, g1_next;

  function automatic logic [7:0] clip_chroma(input logic [31:0] c);
    if ($signed(c) < 32'sd0)        return 8'd0;
    else if ($signed(c) > 32'sd255) return 8'hFF;
    else                            return c[7:0];
  endfunction

  function automatic logic signed [31:0] offs(input logic [7:0] v, input logic [7:0] k);
    return $signed({24'd0, v}) - $signed({24'd0, k});
  endfunction

  function automatic logic [7:0] clip_comp(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    if (s < 32'sd0)        return 8'd0;
    else if (s > 32'sd255) return 8'hFF;
    else                   return s[7:0];
  endfunction

  assign in_ready = (state == IDLE);

  // Operand steering for the two shared multipliers
  always_comb begin
    coef_a = '0;
    coef_b = '0;
    op_a   = '0;
    op_b   = '0;
    case (state)
      M0: begin coef_a = K_Y;  op_a = offs(y0, 8'd16);  coef_b = K_Y;  op_b = offs(y1, 8'd16);  end
      M1: begin coef_a = K_GU; op_a = offs(u0, 8'd128); coef_b = K_BU; op_b = offs(u0, 8'd128); end
      M2: begin coef_a = K_RV; op_a = offs(v0, 8'd128); coef_b = K_GV; op_b = offs(v0, 8'd128); end
      M3: begin coef_a = K_GU; op_a = offs(u1, 8'd128); coef_b = K_BU; op_b = offs(u1, 8'd128); end
      M4: begin coef_a = K_RV; op_a = offs(v1, 8'd128); coef_b = K_GV; op_b = offs(v1, 8'd128); end
      default: ;
    endcase
  end

  assign prod_a  = coef_a * op_a;
  assign prod_b  = coef_b * op_b;
  assign r1_next = acc_r1 + prod_a;
  assign g1_next = acc_g1 + prod_b;

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      RGB_data  <= '0;
      word_sel  <= '0;
      y0 <= '0; y1 <= '0; u0 <= '0; v0 <= '0; u1 <= '0; v1 <= '0;
      acc_r0 <= '0; acc_g0 <= '0; acc_b0 <= '0;
      acc_r1 <= '0; acc_g1 <= '0; acc_b1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            y0    <= Y_data[15:8];
            y1    <= Y_data[7:0];
            u0    <= even_U;
            v0    <= even_V;
            u1    <= clip_chroma(odd_U);
            v1    <= clip_chroma(odd_V);
            state <= M0;
          end
        end
        M0: begin
          acc_r0 <= prod_a;
          acc_g0 <= prod_a;
          acc_b0 <= prod_a;
          acc_r1 <= prod_b;
          acc_g1 <= prod_b;
          acc_b1 <= prod_b;
          state  <= M1;
        end
        M1: begin
          acc_g0 <= acc_g0 + prod_a;
          acc_b0 <= acc_b0 + prod_b;
          state  <= M2;
        end
        M2: begin
          acc_r0 <= acc_r0 + prod_a;
          acc_g0 <= acc_g0 + prod_b;
          state  <= M3;
        end
        M3: begin
          acc_g1 <= acc_g1 + prod_a;
          acc_b1 <= acc_b1 + prod_b;
          state  <= M4;
        end
        M4: begin
          acc_r1    <= r1_next;
          acc_g1    <= g1_next;
          out_valid <= 1'b1;
          RGB_data  <= {clip_comp(acc_r0), clip_comp(acc_g0)};
          word_sel  <= 2'd0;
          state     <= OUT0;
        end
        OUT0: begin
          if (out_ready) begin
            RGB_data <= {clip_comp(acc_b0), clip_comp(acc_r1)};
            word_sel <= 2'd1;
            state    <= OUT1;
          end
        end
        OUT1: begin
          if (out_ready) begin
            RGB_data <= {clip_comp(acc_g1), clip_comp(acc_b1)};
            word_sel <= 2'd2;
            state    <= OUT2;
          end
        end
        OUT2: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CSC_CLIP_COUNT_EN
  function automatic logic is_sat(input logic signed [31:0] acc);
    logic signed [31:0] s;
    s = acc >>> 16;
    return (s < 32'sd0) || (s > 32'sd255);
  endfunction

  logic [15:0] clip_cnt;
  logic [2:0]  sat_num;
  logic [16:0] clip_sum;

  // Odd-pixel R and G are only final once the M4 products are added in
  always_comb begin
    sat_num = 3'(is_sat(acc_r0)) + 3'(is_sat(acc_g0)) + 3'(is_sat(acc_b0)) +
              3'(is_sat(r1_next)) + 3'(is_sat(g1_next)) + 3'(is_sat(acc_b1));
  end

  assign clip_sum = {1'b0, clip_cnt} + {14'd0, sat_num};

  always_ff @(posedge CLOCK_50_I) begin
    if (reset)
      clip_cnt <= '0;
    else if (state == M4)
      clip_cnt <= clip_sum[16] ? 16'hFFFF : clip_sum[15:0];
  end

  assign clip_count = clip_cnt;
`else
  assign clip_count = '0;
`endif

endmodule

// File: tb/tb_yuv_to_rgb_csc.sv
// Scoreboard bench for yuv_to_rgb_csc: directed vectors, chroma clipping,
// back-pressure, mid-operation reset and reset priority.
module tb_yuv_to_rgb_csc;

  logic        CLOCK_50_I = 1'b0;
  logic        reset      = 1'b1;
  logic        in_valid   = 1'b0;
  logic        out_ready  = 1'b1;
  logic [15:0] Y_data     = '0;
  logic [7:0]  even_U     = '0;
  logic [7:0]  even_V     = '0;
  logic [31:0] odd_U      = '0;
  logic [31:0] odd_V      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] RGB_data;
  logic [1:0]  word_sel;
  logic [15:0] clip_count;

  yuv_to_rgb_csc dut (
    .CLOCK_50_I(CLOCK_50_I), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .Y_data(Y_data), .even_U(even_U), .even_V(even_V), .odd_U(odd_U), .odd_V(odd_V),
    .out_valid(out_valid), .out_ready(out_ready), .RGB_data(RGB_data),
    .word_sel(word_sel), .clip_count(clip_count)
  );

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  typedef struct packed {
    logic [15:0] w;
    logic [1:0]  s;
  } exp_t;

  exp_t q[$];
  int   n_cmp    = 0;
  int   n_err    = 0;
  int   exp_clip = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] cl32(input logic [31:0] x);
    int s;
    s = $signed(x);
    if (s < 0)        return 8'd0;
    else if (s > 255) return 8'hFF;
    else              return x[7:0];
  endfunction

  task automatic sat_comp(input int acc, output logic [7:0] c, inout int nc);
    int s;
    if (acc >= 0) s = acc / 65536;
    else          s = -((-acc + 65535) / 65536);
    if (s < 0)        begin c = 8'd0;  nc++; end
    else if (s > 255) begin c = 8'hFF; nc++; end
    else              c = 8'(s);
  endtask

  task automatic model_px(input logic [7:0] y, input logic [7:0] u, input logic [7:0] v,
                          output logic [7:0] r, output logic [7:0] g, output logic [7:0] b,
                          inout int nc);
    int yy, uu, vv;
    yy = int'(y) - 16;
    uu = int'(u) - 128;
    vv = int'(v) - 128;
    sat_comp(76284 * yy + 104595 * vv, r, nc);
    sat_comp(76284 * yy - 25624 * uu - 53281 * vv, g, nc);
    sat_comp(76284 * yy + 132251 * uu, b, nc);
  endtask

  task automatic model_pair(input logic [15:0] y, input logic [7:0] eu, input logic [7:0] ev,
                            input logic [31:0] ou, input logic [31:0] ov,
                            output logic [15:0] w0, output logic [15:0] w1,
                            output logic [15:0] w2, output int nc);
    logic [7:0] r0, g0, b0, r1, g1, b1;
    nc = 0;
    model_px(y[15:8], eu, ev, r0, g0, b0, nc);
    model_px(y[7:0], cl32(ou), cl32(ov), r1, g1, b1, nc);
    w0 = {r0, g0};
    w1 = {b0, r1};
    w2 = {g1, b1};
  endtask

  // Expected words are queued before the accept edge; scrambled inputs follow it
  task automatic accept_pair(input logic [15:0] y, input logic [7:0] eu, input logic [7:0] ev,
                             input logic [31:0] ou, input logic [31:0] ov,
                             input bit push, input bit use_const,
                             input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    logic [15:0] w0, w1, w2;
    int nc, k;
    model_pair(y, eu, ev, ou, ov, w0, w1, w2, nc);
    if (push) begin
      if (use_const) begin w0 = c0; w1 = c1; w2 = c2; end
      q.push_back('{w: w0, s: 2'd0});
      q.push_back('{w: w1, s: 2'd1});
      q.push_back('{w: w2, s: 2'd2});
      exp_clip += nc;
    end
    k = 0;
    @(negedge CLOCK_50_I);
    while (!in_ready && k < 50) begin @(negedge CLOCK_50_I); k++; end
    check("ready_before_accept", 32'(in_ready), 32'd1);
    Y_data = y; even_U = eu; even_V = ev; odd_U = ou; odd_V = ov;
    in_valid = 1'b1;
    @(posedge CLOCK_50_I);
    #1;
    in_valid = 1'b0;
    Y_data = 16'($urandom); even_U = 8'($urandom); even_V = 8'($urandom);
    odd_U = $urandom; odd_V = $urandom;
  endtask

  task automatic wait_idle_and_check_clip();
    int k;
    k = 0;
    @(negedge CLOCK_50_I);
    while (!in_ready && k < 100) begin @(negedge CLOCK_50_I); k++; end
    check("return_idle", 32'(in_ready), 32'd1);
`ifdef CSC_CLIP_COUNT_EN
    check("clip_count", 32'(clip_count), 32'(exp_clip));
`else
    check("clip_count", 32'(clip_count), 32'd0);
`endif
  endtask

  task automatic send_pair(input logic [15:0] y, input logic [7:0] eu, input logic [7:0] ev,
                           input logic [31:0] ou, input logic [31:0] ov, input bit use_const,
                           input logic [15:0] c0, input logic [15:0] c1, input logic [15:0] c2);
    int n;
    accept_pair(y, eu, ev, ou, ov, 1'b1, use_const, c0, c1, c2);
    n = 0;
    @(negedge CLOCK_50_I);
    while (!out_valid && n < 20) begin n++; @(negedge CLOCK_50_I); end
    check("first_word_latency", 32'(n), 32'd5);
    wait_idle_and_check_clip();
  endtask

  always @(negedge CLOCK_50_I) begin
    if (!reset && out_valid && out_ready) begin
      n_cmp++;
      assert (q.size() > 0) else begin
        n_err++;
        $error("FAIL unexpected_word observed=%0h expected=none", RGB_data);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        check("rgb_word", 32'(RGB_data), 32'(e.w));
        check("word_sel", 32'(word_sel), 32'(e.s));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int t;

    // Reset state
    repeat (3) @(posedge CLOCK_50_I);
    #1 reset = 1'b0;
    @(negedge CLOCK_50_I);
    check("rst_in_ready",   32'(in_ready),   32'd1);
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_rgb_data",   32'(RGB_data),   32'd0);
    check("rst_word_sel",   32'(word_sel),   32'd0);
    check("rst_clip_count", 32'(clip_count), 32'd0);

    // Directed vectors with hand-derived words
    send_pair(16'h1010, 8'd128, 8'd128, 32'd128, 32'd128, 1'b1, 16'h0000, 16'h0000, 16'h0000);
    send_pair(16'hEBFF, 8'd128, 8'd128, 32'd128, 32'd128, 1'b1, 16'hFEFE, 16'hFEFF, 16'hFFFF);
    send_pair(16'h5151, 8'd128, 8'd240, 32'd240 - 32'd112, 32'd240, 1'b1, 16'hFE00, 16'h4BFE, 16'h004B);

    // Out-of-range interpolated chroma clipped before use
    send_pair(16'h8040, 8'd90, 8'd200, 32'hFFFFFFF0, 32'h00000190, 1'b0, 16'h0, 16'h0, 16'h0);

    // Assorted pixel pairs through the reference model
    for (int i = 0; i < 4; i++) begin
      logic [31:0] ou, ov;
      t  = int'($urandom_range(0, 900)) - 300;
      ou = t;
      t  = int'($urandom_range(0, 900)) - 300;
      ov = t;
      send_pair(16'($urandom), 8'($urandom), 8'($urandom), ou, ov, 1'b0, 16'h0, 16'h0, 16'h0);
    end

    // Back-pressure held in OUT1
    accept_pair(16'h5151, 8'd128, 8'd240, 32'd128, 32'd240, 1'b1, 1'b1, 16'hFE00, 16'h4BFE, 16'h004B);
    k = 0;
    @(negedge CLOCK_50_I);
    while (!(out_valid && word_sel == 2'd0) && k < 20) begin @(negedge CLOCK_50_I); k++; end
    check("stall_reach_out0", 32'(out_valid), 32'd1);
    @(posedge CLOCK_50_I);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50_I);
      check("stall_rgb_hold",  32'(RGB_data),  32'h4BFE);
      check("stall_sel_hold",  32'(word_sel),  32'd1);
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge CLOCK_50_I);
    #1 out_ready = 1'b1;
    @(negedge CLOCK_50_I);
    @(negedge CLOCK_50_I);
    check("stall_then_out2_sel",   32'(word_sel),  32'd2);
    check("stall_then_out2_valid", 32'(out_valid), 32'd1);
    wait_idle_and_check_clip();

    // Reset while in M2 discards the pair
    accept_pair(16'hEBFF, 8'd50, 8'd60, 32'd70, 32'd80, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
    @(posedge CLOCK_50_I);
    #1;
    @(posedge CLOCK_50_I);
    #1 reset = 1'b1;
    @(posedge CLOCK_50_I);
    #1 reset = 1'b0;
    exp_clip = 0;
    @(negedge CLOCK_50_I);
    check("m2rst_in_ready",   32'(in_ready),   32'd1);
    check("m2rst_out_valid",  32'(out_valid),  32'd0);
    check("m2rst_clip_count", 32'(clip_count), 32'd0);
    repeat (8) @(negedge CLOCK_50_I);
    send_pair(16'hEBFF, 8'd128, 8'd128, 32'd128, 32'd128, 1'b1, 16'hFEFE, 16'hFEFF, 16'hFFFF);

    // Reset wins over a simultaneous accept
    @(negedge CLOCK_50_I);
    reset    = 1'b1;
    in_valid = 1'b1;
    Y_data   = 16'hEBFF;
    @(posedge CLOCK_50_I);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_clip = 0;
    @(negedge CLOCK_50_I);
    check("rst_prio_in_ready",  32'(in_ready),  32'd1);
    check("rst_prio_out_valid", 32'(out_valid), 32'd0);
    repeat (12) @(negedge CLOCK_50_I);
    check("queue_drained", 32'(q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
